// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt request unit: defaults, the channel-id type
// for the default configuration, and the rotating priority rank helper.
package pic_pkg;

  localparam int unsigned DefNumIrq     = 8;
  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefIdW        = $clog2(DefNumIrq);

  typedef logic [DefIdW-1:0] chan_id_t;

  // Rank 0 is the highest priority; the channel just after 'lowest' gets rank 0.
  function automatic int unsigned prio_rank(int unsigned id, int unsigned lowest,
                                            int unsigned n);
    return (id + n - lowest - 1) % n;
  endfunction

endpackage

// File: rtl/pic_prio_find.sv
// Rotating find-first: returns the set bit of vec_i with the lowest priority rank
// relative to lowest_prio_i.
module pic_prio_find
  import pic_pkg::*;
#(
  parameter int unsigned NumIrq = DefNumIrq,
  parameter int unsigned IdW    = $clog2(NumIrq)
) (
  input  logic [NumIrq-1:0] vec_i,
  input  logic [IdW-1:0]    lowest_prio_i,
  output logic              found_o,
  output logic [IdW-1:0]    id_o
);

  always_comb begin
    int unsigned idx;
    found_o = 1'b0;
    id_o    = '0;
    idx     = 0;
    // Walk from the worst rank down so the last hit is the best-ranked channel.
    for (int unsigned r = NumIrq; r > 0; r--) begin
      idx = (32'(lowest_prio_i) + r) % NumIrq;
      if (vec_i[idx[IdW-1:0]]) begin
        found_o = 1'b1;
        id_o    = idx[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/irq_request_unit.sv
// Clocked 8259-style request unit: input synchronisers, edge/level IRR capture,
// masking, in-service register and fully-nested rotating priority arbitration.
module irq_request_unit
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = DefNumIrq,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned ID_W        = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               level_mode,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               rotate_en,
  input  logic               ack,
  input  logic               eoi,
  input  logic               eoi_specific,
  input  logic [ID_W-1:0]    eoi_id,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr
);

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] prev_q, irr_q, isr_q;
  logic [NUM_IRQ-1:0] irr_d, isr_d;
  logic               int_req_q;
  logic [ID_W-1:0]    int_id_q, int_id_d;
  logic [ID_W-1:0]    lowest_prio_q, lowest_prio_d;

  logic [NUM_IRQ-1:0] sync_s, cand, ack_set, eoi_clr;
  logic               win_found, svc_found, req_ok, ack_fire, eoi_hit;
  logic [ID_W-1:0]    win_id, svc_id, eoi_k;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign cand   = irr_q & ~mask;

  pic_prio_find #(
    .NumIrq (NUM_IRQ),
    .IdW    (ID_W)
  ) u_find_cand (
    .vec_i         (cand),
    .lowest_prio_i (lowest_prio_q),
    .found_o       (win_found),
    .id_o          (win_id)
  );

  pic_prio_find #(
    .NumIrq (NUM_IRQ),
    .IdW    (ID_W)
  ) u_find_svc (
    .vec_i         (isr_q),
    .lowest_prio_i (lowest_prio_q),
    .found_o       (svc_found),
    .id_o          (svc_id)
  );

  // Fully nested: only a strictly higher-ranked request may interrupt service.
  assign req_ok = win_found &&
                  (!svc_found ||
                   (prio_rank(32'(win_id), 32'(lowest_prio_q), NUM_IRQ) <
                    prio_rank(32'(svc_id), 32'(lowest_prio_q), NUM_IRQ)));

  assign ack_fire = ack & int_req_q;
  assign ack_set  = ack_fire ? (NUM_IRQ'(1) << int_id_q) : '0;

  // EOI target is decoded from the pre-update ISR.
  always_comb begin
    eoi_hit = 1'b0;
    eoi_k   = svc_id;
    if (eoi) begin
      if (eoi_specific) begin
        if ((32'(eoi_id) < NUM_IRQ) && isr_q[eoi_id]) begin
          eoi_hit = 1'b1;
          eoi_k   = eoi_id;
        end
      end else if (svc_found) begin
        eoi_hit = 1'b1;
        eoi_k   = svc_id;
      end
    end
  end

  assign eoi_clr = eoi_hit ? (NUM_IRQ'(1) << eoi_k) : '0;

  always_comb begin
    isr_d         = (isr_q & ~eoi_clr) | ack_set;
    irr_d         = level_mode ? sync_s : ((irr_q & ~ack_set) | (sync_s & ~prev_q));
    lowest_prio_d = (rotate_en && eoi_hit) ? eoi_k : lowest_prio_q;
    int_id_d      = req_ok ? win_id : int_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
      prev_q        <= '0;
      irr_q         <= '0;
      isr_q         <= '0;
      int_req_q     <= 1'b0;
      int_id_q      <= '0;
      lowest_prio_q <= ID_W'(NUM_IRQ - 1);
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q        <= sync_s;
      irr_q         <= irr_d;
      isr_q         <= isr_d;
      int_req_q     <= req_ok;
      int_id_q      <= int_id_d;
      lowest_prio_q <= lowest_prio_d;
    end
  end

  assign int_req = int_req_q;
  assign int_id  = int_id_q;
  assign irr     = irr_q;
  assign isr     = isr_q;

endmodule

// File: tb/tb_irq_request_unit.sv
// Scoreboarded bench for irq_request_unit: a behavioural model predicts the outputs
// after each clock; a negedge monitor pops and compares them.
module tb_irq_request_unit;

  localparam int N  = 8;
  localparam int SS = 2;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic          level_mode = 1'b0;
  logic [N-1:0]  mask = '0;
  logic          rotate_en = 1'b0;
  logic          ack = 1'b0;
  logic          eoi = 1'b0;
  logic          eoi_specific = 1'b0;
  logic [IW-1:0] eoi_id = '0;
  logic          int_req;
  logic [IW-1:0] int_id;
  logic [N-1:0]  irr, isr;

  always #5 clk = ~clk;

  irq_request_unit #(
    .NUM_IRQ     (N),
    .SYNC_STAGES (SS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_in       (irq_in),
    .level_mode   (level_mode),
    .mask         (mask),
    .rotate_en    (rotate_en),
    .ack          (ack),
    .eoi          (eoi),
    .eoi_specific (eoi_specific),
    .eoi_id       (eoi_id),
    .int_req      (int_req),
    .int_id       (int_id),
    .irr          (irr),
    .isr          (isr)
  );

  typedef struct packed {
    logic [N-1:0]  irr;
    logic [N-1:0]  isr;
    logic          req;
    logic [IW-1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  logic [N-1:0] m_pipe[$];
  logic [N-1:0] m_prev, m_irr, m_isr;
  bit           m_req;
  int           m_id, m_lp;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int rank(input int i, input int lp);
    return (((i - lp - 1) % N) + N) % N;
  endfunction

  function automatic int best(input logic [N-1:0] v, input int lp);
    int b = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i] && (b < 0 || rank(i, lp) < rank(b, lp))) b = i;
    end
    return b;
  endfunction

  task automatic model_reset();
    m_pipe.delete();
    repeat (SS) m_pipe.push_back('0);
    m_prev = '0;
    m_irr  = '0;
    m_isr  = '0;
    m_req  = 1'b0;
    m_id   = 0;
    m_lp   = N - 1;
  endtask

  task automatic model_step();
    logic [N-1:0] s, cand, ackset, clr, irr_n;
    int w, v, k;
    bit ok;
    s    = m_pipe[0];
    cand = m_irr & ~mask;
    w    = best(cand, m_lp);
    v    = best(m_isr, m_lp);
    ok   = (w >= 0) && (v < 0 || rank(w, m_lp) < rank(v, m_lp));
    ackset = '0;
    if (ack && m_req) ackset[m_id] = 1'b1;
    k = -1;
    if (eoi) begin
      if (eoi_specific) begin
        if (int'(eoi_id) < N && m_isr[eoi_id]) k = int'(eoi_id);
      end else begin
        k = v;
      end
    end
    clr = '0;
    if (k >= 0) clr[k] = 1'b1;
    irr_n = level_mode ? s : ((m_irr & ~ackset) | (s & ~m_prev));
    m_irr = irr_n;
    m_isr = (m_isr & ~clr) | ackset;
    if (rotate_en && k >= 0) m_lp = k;
    m_req = ok;
    if (ok) m_id = w;
    m_prev = s;
    void'(m_pipe.pop_front());
    m_pipe.push_back(irq_in);
  endtask

  function automatic exp_t cur_exp();
    exp_t e;
    e.irr = m_irr;
    e.isr = m_isr;
    e.req = m_req;
    e.id  = IW'(m_id);
    return e;
  endfunction

  // One clock: model advances on the edge, pulses drop, expectation is queued.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    ack = 1'b0;
    eoi = 1'b0;
    exp_q.push_back(cur_exp());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    exp_q.push_back(cur_exp());
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_irr", int'(irr), int'(e.irr));
      chk("sb_isr", int'(isr), int'(e.isr));
      chk("sb_int_req", int'(int_req), int'(e.req));
      if (e.req) chk("sb_int_id", int'(int_id), int'(e.id));
    end
  end

  initial begin
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;

    // Edge pulse on channel 3: latency, ack, non-specific EOI
    irq_in = 8'h08; tick(); irq_in = '0;
    tick();
    chk("edge_irr_early", int'(irr), 0);
    tick();
    chk("edge_irr_latency", int'(irr), 8'h08);
    chk("edge_req_not_yet", int'(int_req), 0);
    tick();
    chk("edge_int_req", int'(int_req), 1);
    chk("edge_int_id", int'(int_id), 3);
    ack = 1'b1; tick();
    chk("ack_isr", int'(isr), 8'h08);
    chk("ack_irr_clr", int'(irr), 0);
    tick();
    chk("ack_req_drop", int'(int_req), 0);
    eoi = 1'b1; tick();
    chk("eoi_isr_clr", int'(isr), 0);

    // Mask holds off a pending request without touching irr
    mask = 8'h01; irq_in = 8'h01;
    repeat (SS + 2) tick();
    chk("mask_irr", int'(irr), 8'h01);
    chk("mask_no_req", int'(int_req), 0);
    mask = '0; tick();
    chk("unmask_req", int'(int_req), 1);
    chk("unmask_id", int'(int_id), 0);
    ack = 1'b1; tick(); tick();
    eoi = 1'b1; tick();
    irq_in = '0; tick();

    // Rotation: serve 0 then 1, then 2 must beat 0
    rotate_en = 1'b1;
    irq_in = 8'h03; tick(); irq_in = '0;
    repeat (SS) tick();
    tick();
    chk("rot_first_id", int'(int_id), 0);
    ack = 1'b1; tick(); tick();
    eoi = 1'b1; tick(); tick();
    chk("rot_second_id", int'(int_id), 1);
    ack = 1'b1; tick(); tick();
    eoi = 1'b1; tick();
    irq_in = 8'h05; tick(); irq_in = '0;
    repeat (SS) tick();
    tick();
    chk("rot_req", int'(int_req), 1);
    chk("rot_id_after", int'(int_id), 2);
    rotate_en = 1'b0;

    // Reset mid-service, then 7 and 0 together resolve to 0
    irq_in = 8'h08; tick(); irq_in = '0;
    repeat (SS + 1) tick();
    ack = 1'b1; tick();
    do_reset();
    #1;
    chk("rst_isr", int'(isr), 0);
    chk("rst_irr", int'(irr), 0);
    chk("rst_int_req", int'(int_req), 0);
    chk("rst_int_id", int'(int_id), 0);
    tick(); rst_n = 1'b1;
    irq_in = 8'h81; tick(); irq_in = '0;
    repeat (SS) tick();
    tick();
    chk("post_rst_req", int'(int_req), 1);
    chk("post_rst_id", int'(int_id), 0);

    // Randomised traffic, checked entirely by the scoreboard
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
        tick();
        rst_n = 1'b1;
        continue;
      end
      irq_in = irq_in ^ N'($urandom() & $urandom() & $urandom());
      if ($urandom_range(31) == 0) mask = N'($urandom() & $urandom());
      if ($urandom_range(199) == 0) level_mode = ~level_mode;
      if ($urandom_range(99) == 0) rotate_en = ~rotate_en;
      ack          = ($urandom_range(3) == 0);
      eoi          = ($urandom_range(5) == 0);
      eoi_specific = $urandom_range(1) == 1;
      eoi_id       = IW'($urandom_range(N - 1));
      tick();
    end

    tick();
    @(negedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
